// File: rtl/alu_muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : alu_muldiv_pkg                                               |
// | Description : Shared opcode / function-field encodings and multiply-divide |
// |               sequencer state type for the alu_muldiv execute-stage ALU.   |
// |               ALU_ITERATIVE_MULT_EN adds the S_MUL sequencer state.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_muldiv_pkg;

  // Primary opcode field (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function field (instr[5:0])
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // Multiply/divide sequencer states
`ifdef ALU_ITERATIVE_MULT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd2
  } md_state_t;
`endif

endpackage : alu_muldiv_pkg
`default_nettype wire

// File: rtl/alu_muldiv_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : alu_muldiv_if                                                |
// | Description : Operand / result bundle between the pipeline control (master)|
// |               and the alu_muldiv execute-stage ALU (slave).                |
// |   op1, op2      master->slave  rs value, rt value or extended immediate    |
// |   ALUOp         master->slave  opcode field                                |
// |   func_code     master->slave  R-type function field                       |
// |   shamt         master->slave  shift amount                                |
// |   in_valid      master->slave  instruction present; gates HI/LO/FSM        |
// |   alu_out       slave->master  combinational result                        |
// |   busy          slave->master  multi-cycle op in flight (stall)            |
// |   hi, lo        slave->master  HI/LO register contents                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface alu_muldiv_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic [5:0]         ALUOp;
  logic [5:0]         func_code;
  logic [SHAMT_W-1:0] shamt;
  logic               in_valid;
  logic [WIDTH-1:0]   alu_out;
  logic               busy;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  modport master (
    output op1, op2, ALUOp, func_code, shamt, in_valid,
    input  alu_out, busy, hi, lo
  );

  modport slave (
    input  op1, op2, ALUOp, func_code, shamt, in_valid,
    output alu_out, busy, hi, lo
  );
endinterface : alu_muldiv_if
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_seq                                                   |
// | Description : HI/LO registers plus the multi-cycle sequencer: restoring    |
// |               divider (one quotient bit per cycle, magnitudes + sign fix). |
// |               With ALU_ITERATIVE_MULT_EN multiply runs as a shift-add      |
// |               sequence on the same registers; otherwise the full product   |
// |               arrives on prod and is written in one cycle.                 |
// |   clk, reset         clock, asynchronous active-high reset                 |
// |   in_valid           instruction present this cycle                        |
// |   do_mthi/do_mtlo    write HI/LO from op1                                  |
// |   do_mult/do_div     start multiply / divide; is_signed selects signed     |
// |   op1, op2           operands (dividend/divisor, multiplicands)            |
// |   prod               full product (single-cycle multiply build only)       |
// |   hi, lo, busy       registered outputs                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               do_mthi,
  input  logic               do_mtlo,
  input  logic               do_mult,
  input  logic               do_div,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
`ifndef ALU_ITERATIVE_MULT_EN
  input  logic [2*WIDTH-1:0] prod,
`endif
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH-1);

  md_state_t        r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt,   w_cnt_n;
  logic [WIDTH-1:0] r_rem,   w_rem_n;   // partial remainder / product high half
  logic [WIDTH-1:0] r_quo,   w_quo_n;   // dividend->quotient / multiplier->product low half
  logic [WIDTH-1:0] r_dvs,   w_dvs_n;   // divisor / multiplicand magnitude
  logic             r_neg_q, w_neg_q_n; // negate quotient (or product)
  logic             r_neg_r, w_neg_r_n; // negate remainder
  logic             r_divz,  w_divz_n;
  logic [WIDTH-1:0] r_hi,    w_hi_n;
  logic [WIDTH-1:0] r_lo,    w_lo_n;
  logic             r_busy;

  // Operand magnitudes for the signed variants
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  assign w_a_neg = is_signed & op1[WIDTH-1];
  assign w_b_neg = is_signed & op2[WIDTH-1];
  assign w_a_mag = w_a_neg ? -op1 : op1;
  assign w_b_mag = w_b_neg ? -op2 : op2;

  // One restoring-division step: shift the next dividend bit into the remainder
  // and subtract when it fits. The shifted value needs WIDTH+1 bits, but a
  // successful difference is below the divisor, so WIDTH bits hold it.
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_rem, w_div_quo, w_q_fix, w_r_fix;
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dvs});
  assign w_div_rem = w_ge ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
  assign w_div_quo = {r_quo[WIDTH-2:0], w_ge};
  assign w_q_fix   = r_neg_q ? -w_div_quo : w_div_quo;
  assign w_r_fix   = r_neg_r ? -w_div_rem : w_div_rem;

`ifdef ALU_ITERATIVE_MULT_EN
  // One shift-add step: add multiplicand when the multiplier LSB is set, then
  // shift the {high, low} pair right; the carry lands in the high half's MSB.
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  assign w_sum      = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_dvs} : {(WIDTH+1){1'b0}});
  assign w_prod     = {w_sum, r_quo[WIDTH-1:1]};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
`endif

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_rem_n   = r_rem;
    w_quo_n   = r_quo;
    w_dvs_n   = r_dvs;
    w_neg_q_n = r_neg_q;
    w_neg_r_n = r_neg_r;
    w_divz_n  = r_divz;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (do_mthi) w_hi_n = op1;
          if (do_mtlo) w_lo_n = op1;
          if (do_div) begin
            w_state_n = S_DIV;
            w_cnt_n   = '0;
            w_rem_n   = '0;
            w_quo_n   = w_a_mag;
            w_dvs_n   = w_b_mag;
            w_neg_q_n = w_a_neg ^ w_b_neg;
            w_neg_r_n = w_a_neg;
            w_divz_n  = (op2 == '0);
          end
`ifdef ALU_ITERATIVE_MULT_EN
          if (do_mult) begin
            w_state_n = S_MUL;
            w_cnt_n   = '0;
            w_rem_n   = '0;
            w_quo_n   = w_b_mag;
            w_dvs_n   = w_a_mag;
            w_neg_q_n = w_a_neg ^ w_b_neg;
          end
`else
          if (do_mult) begin
            w_hi_n = prod[2*WIDTH-1:WIDTH];
            w_lo_n = prod[WIDTH-1:0];
          end
`endif
        end
      end
      S_DIV: begin
        w_rem_n = w_div_rem;
        w_quo_n = w_div_quo;
        w_cnt_n = r_cnt + CNT_W'(1);
        if (r_cnt == C_LAST) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_hi_n    = w_r_fix;
          // Divide by zero: remainder path already reproduces the dividend
          w_lo_n    = r_divz ? '1 : w_q_fix;
        end
      end
`ifdef ALU_ITERATIVE_MULT_EN
      S_MUL: begin
        w_rem_n = w_prod[2*WIDTH-1:WIDTH];
        w_quo_n = w_prod[WIDTH-1:0];
        w_cnt_n = r_cnt + CNT_W'(1);
        if (r_cnt == C_LAST) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_hi_n    = w_prod_fix[2*WIDTH-1:WIDTH];
          w_lo_n    = w_prod_fix[WIDTH-1:0];
        end
      end
`endif
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_divz  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_rem   <= w_rem_n;
      r_quo   <= w_quo_n;
      r_dvs   <= w_dvs_n;
      r_neg_q <= w_neg_q_n;
      r_neg_r <= w_neg_r_n;
      r_divz  <= w_divz_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
      r_busy  <= (w_state_n != S_IDLE);
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;

endmodule : muldiv_seq
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_muldiv                                                   |
// | Description : Execute-stage MIPS-I integer ALU with HI/LO registers and a  |
// |               multi-cycle divider (busy/stall handshake). Decode and the   |
// |               result mux live here; sequencing lives in muldiv_seq.        |
// |               Define ALU_ITERATIVE_MULT_EN for a shift-add multiplier      |
// |               instead of the single-cycle array multiplier.                |
// |   clk        clock, rising edge                                            |
// |   reset      asynchronous, active-high                                     |
// |   bus        alu_muldiv_if.slave: operands, opcode/func, shamt, in_valid,  |
// |              alu_out, busy, hi, lo                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = $clog2(WIDTH+1)
) (
  input  logic         clk,
  input  logic         reset,
  alu_muldiv_if.slave  bus
);

  logic             w_is_r;
  logic             w_do_mthi, w_do_mtlo, w_do_mult, w_do_div, w_is_signed;
  logic [WIDTH-1:0] w_hi, w_lo;
  logic             w_busy;
  logic             w_lt_s, w_lt_u;
  logic [WIDTH-1:0] w_result;

  assign w_is_r      = (bus.ALUOp == OP_RTYPE);
  assign w_do_mthi   = w_is_r && (bus.func_code == FN_MTHI);
  assign w_do_mtlo   = w_is_r && (bus.func_code == FN_MTLO);
  assign w_do_mult   = w_is_r && ((bus.func_code == FN_MULT) || (bus.func_code == FN_MULTU));
  assign w_do_div    = w_is_r && ((bus.func_code == FN_DIV)  || (bus.func_code == FN_DIVU));
  assign w_is_signed = (bus.func_code == FN_MULT) || (bus.func_code == FN_DIV);

`ifndef ALU_ITERATIVE_MULT_EN
  // Extending both operands to 2*WIDTH makes the truncated product exact for
  // signed and unsigned alike.
  logic [2*WIDTH-1:0] w_ext1, w_ext2, w_prod;
  assign w_ext1 = w_is_signed ? {{WIDTH{bus.op1[WIDTH-1]}}, bus.op1} : {{WIDTH{1'b0}}, bus.op1};
  assign w_ext2 = w_is_signed ? {{WIDTH{bus.op2[WIDTH-1]}}, bus.op2} : {{WIDTH{1'b0}}, bus.op2};
  assign w_prod = w_ext1 * w_ext2;
`endif

  muldiv_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .do_mthi   (w_do_mthi),
    .do_mtlo   (w_do_mtlo),
    .do_mult   (w_do_mult),
    .do_div    (w_do_div),
    .is_signed (w_is_signed),
    .op1       (bus.op1),
    .op2       (bus.op2),
`ifndef ALU_ITERATIVE_MULT_EN
    .prod      (w_prod),
`endif
    .hi        (w_hi),
    .lo        (w_lo),
    .busy      (w_busy)
  );

  assign w_lt_s = ($signed(bus.op1) < $signed(bus.op2));
  assign w_lt_u = (bus.op1 < bus.op2);

  always_comb begin
    w_result = '0;
    case (bus.ALUOp)
      OP_RTYPE: begin
        case (bus.func_code)
          FN_SLL:  w_result = bus.op2 << bus.shamt;
          FN_SRL:  w_result = bus.op2 >> bus.shamt;
          FN_SRA:  w_result = $signed(bus.op2) >>> bus.shamt;
          FN_SLLV: w_result = bus.op2 << bus.op1[SHAMT_W-1:0];
          FN_SRLV: w_result = bus.op2 >> bus.op1[SHAMT_W-1:0];
          FN_SRAV: w_result = $signed(bus.op2) >>> bus.op1[SHAMT_W-1:0];
          FN_MFHI: w_result = w_hi;
          FN_MFLO: w_result = w_lo;
          FN_ADDU: w_result = bus.op1 + bus.op2;
          FN_SUBU: w_result = bus.op1 - bus.op2;
          FN_AND:  w_result = bus.op1 & bus.op2;
          FN_OR:   w_result = bus.op1 | bus.op2;
          FN_XOR:  w_result = bus.op1 ^ bus.op2;
          FN_NOR:  w_result = ~(bus.op1 | bus.op2);
          FN_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_lt_s};
          FN_SLTU: w_result = {{(WIDTH-1){1'b0}}, w_lt_u};
          default: w_result = '0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: w_result = bus.op1 + bus.op2;
      OP_SLTI:  w_result = {{(WIDTH-1){1'b0}}, w_lt_s};
      OP_SLTIU: w_result = {{(WIDTH-1){1'b0}}, w_lt_u};
      OP_ANDI:  w_result = bus.op1 & bus.op2;
      OP_ORI:   w_result = bus.op1 | bus.op2;
      OP_XORI:  w_result = bus.op1 ^ bus.op2;
      OP_LUI:   w_result = bus.op2 << (WIDTH/2);
      default:  w_result = '0;
    endcase
  end

  assign bus.alu_out = w_result;
  assign bus.busy    = w_busy;
  assign bus.hi      = w_hi;
  assign bus.lo      = w_lo;

endmodule : alu_muldiv
`default_nettype wire
